// File: rtl/uart_rx.sv
`default_nettype none
//==============================================================================
// Module   : uart_rx
// Desc     : Oversampling UART receiver. RXD is re-timed by a 2-flop
//            synchroniser, the start bit is validated at mid-bit, SIZE data
//            bits are captured LSB-first and the stop bit is checked. The
//            received word is offered on a valid/ack handshake with sticky
//            FRAME_ERR and OVERRUN flags.
//            Optional feature macro: UART_RX_PARITY_EN adds an even-parity
//            bit after the data and a sticky PARITY_ERR output.
// Revision : 1.0  initial release
//==============================================================================
module uart_rx #(
   parameter int SIZE = 8,
   parameter int OSR  = 16
) (
   input  logic            RXC,
   input  logic            R_N,
   input  logic            RXD,
   output logic [SIZE-1:0] RXDATA,
   output logic            RX_VALID,
   input  logic            RX_ACK,
   output logic            RX_BUSY,
   output logic            FRAME_ERR,
   output logic            OVERRUN,
`ifdef UART_RX_PARITY_EN
   output logic            PARITY_ERR,
`endif
   input  logic            ERR_CLR
);

   localparam int c_tick_w = $clog2(OSR);
   localparam int c_bit_w  = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam logic [c_tick_w-1:0] c_tick_half = c_tick_w'(OSR / 2);
   localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(OSR - 1);
   localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(SIZE - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_STOP      = 3'd3,
`ifdef UART_RX_PARITY_EN
      S_PARITY    = 3'd5,
`endif
      S_WAIT_HIGH = 3'd4
   } state_t;

   logic                r_sync1;
   logic                r_rxd_s;
   state_t              r_state;
   state_t              w_state_nx;
   logic [c_tick_w-1:0] r_tick;
   logic [c_tick_w-1:0] w_tick_nx;
   logic [c_bit_w-1:0]  r_bit;
   logic [c_bit_w-1:0]  w_bit_nx;
   logic [SIZE-1:0]     r_shift;
   logic                w_shift_en;
   logic                w_deliver;
   logic                w_ferr_set;
`ifdef UART_RX_PARITY_EN
   logic                r_par_bad;
   logic                w_par_bad_nx;
   logic                w_perr_set;
`endif

   // Two-flop synchroniser; idles high so reset never looks like a start bit.
   always_ff @(posedge RXC or negedge R_N) begin
      if (!R_N) begin
         r_sync1 <= 1'b1;
         r_rxd_s <= 1'b1;
      end else begin
         r_sync1 <= RXD;
         r_rxd_s <= r_sync1;
      end
   end

   // Frame state register.
   always_ff @(posedge RXC or negedge R_N) begin
      if (!R_N) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Next-state, counter and strobe decode; the tick counter free-runs
   // modulo OSR so every bit boundary lands on the same tick value.
   always_comb begin
      w_state_nx = r_state;
      w_tick_nx  = (r_tick == c_tick_last) ? '0 : r_tick + c_tick_w'(1);
      w_bit_nx   = r_bit;
      w_shift_en = 1'b0;
      w_deliver  = 1'b0;
      w_ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_bad_nx = r_par_bad;
      w_perr_set   = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            w_tick_nx = '0;
            if (!r_rxd_s) begin
               w_state_nx = S_START;
            end
         end
         S_START: begin
`ifdef UART_RX_PARITY_EN
            w_par_bad_nx = 1'b0;
`endif
            if (r_tick == c_tick_half) begin
               w_tick_nx  = '0;
               w_bit_nx   = '0;
               // A line that is high again at mid-start was only a glitch.
               w_state_nx = r_rxd_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (r_tick == c_tick_last) begin
               w_shift_en = 1'b1;
               if (r_bit == c_bit_last) begin
`ifdef UART_RX_PARITY_EN
                  w_state_nx = S_PARITY;
`else
                  w_state_nx = S_STOP;
`endif
               end else begin
                  w_bit_nx = r_bit + c_bit_w'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (r_tick == c_tick_last) begin
               // Even parity: the parity bit equals the XOR of the data bits.
               if (r_rxd_s != (^r_shift)) begin
                  w_perr_set   = 1'b1;
                  w_par_bad_nx = 1'b1;
               end
               w_state_nx = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (r_tick == c_tick_last) begin
               if (r_rxd_s) begin
`ifdef UART_RX_PARITY_EN
                  w_deliver = !r_par_bad;
`else
                  w_deliver = 1'b1;
`endif
                  w_state_nx = S_IDLE;
               end else begin
                  w_ferr_set = 1'b1;
                  w_state_nx = S_WAIT_HIGH;
               end
            end
         end
         S_WAIT_HIGH: begin
            // Hold off on a broken/held-low line until it returns to idle.
            w_tick_nx = '0;
            if (r_rxd_s) begin
               w_state_nx = S_IDLE;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // Tick/bit counters and the LSB-first shift register.
   always_ff @(posedge RXC or negedge R_N) begin
      if (!R_N) begin
         r_tick  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
      end else begin
         r_tick <= w_tick_nx;
         r_bit  <= w_bit_nx;
         if (w_shift_en) begin
            r_shift <= {r_rxd_s, r_shift[SIZE-1:1]};
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   // Parity verdict for the current frame and its sticky host flag.
   always_ff @(posedge RXC or negedge R_N) begin
      if (!R_N) begin
         r_par_bad  <= 1'b0;
         PARITY_ERR <= 1'b0;
      end else begin
         r_par_bad <= w_par_bad_nx;
         if (w_perr_set) begin
            PARITY_ERR <= 1'b1;
         end else if (ERR_CLR) begin
            PARITY_ERR <= 1'b0;
         end
      end
   end
`endif

   // Host handshake and sticky errors; a new error event beats ERR_CLR.
   always_ff @(posedge RXC or negedge R_N) begin
      if (!R_N) begin
         RXDATA    <= '0;
         RX_VALID  <= 1'b0;
         FRAME_ERR <= 1'b0;
         OVERRUN   <= 1'b0;
      end else begin
         if (w_deliver && (!RX_VALID || RX_ACK)) begin
            RXDATA   <= r_shift;
            RX_VALID <= 1'b1;
         end else if (RX_ACK) begin
            RX_VALID <= 1'b0;
         end

         if (w_deliver && RX_VALID && !RX_ACK) begin
            OVERRUN <= 1'b1;
         end else if (ERR_CLR) begin
            OVERRUN <= 1'b0;
         end

         if (w_ferr_set) begin
            FRAME_ERR <= 1'b1;
         end else if (ERR_CLR) begin
            FRAME_ERR <= 1'b0;
         end
      end
   end

   assign RX_BUSY = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
//==============================================================================
// Module   : tb_uart_rx
// Desc     : Self-checking bench for uart_rx. A frame-level model schedules
//            each frame's outcome from its start time and the frame latency,
//            applies the handshake rules, and is compared with the DUT on
//            every cycle; literal checks pin key values.
// Revision : 1.0  initial release
//==============================================================================
module tb_uart_rx;

   localparam int SIZE = 8;
   localparam int OSR  = 16;
`ifdef UART_RX_PARITY_EN
   localparam int PAR     = 1;
   localparam int LAT_LIT = 171;
`else
   localparam int PAR     = 0;
   localparam int LAT_LIT = 155;
`endif
   localparam int LAT = 3 + OSR / 2 + (SIZE + 1 + PAR) * OSR;

   logic            rxc     = 1'b0;
   logic            rst_n   = 1'b0;
   logic            rxd     = 1'b1;
   logic            rx_ack  = 1'b0;
   logic            err_clr = 1'b0;
   logic [SIZE-1:0] rxdata;
   logic            rx_valid;
   logic            rx_busy;
   logic            frame_err;
   logic            overrun;
`ifdef UART_RX_PARITY_EN
   logic            parity_err;
`endif

   uart_rx #(.SIZE(SIZE), .OSR(OSR)) dut (
      .RXC       (rxc),
      .R_N       (rst_n),
      .RXD       (rxd),
      .RXDATA    (rxdata),
      .RX_VALID  (rx_valid),
      .RX_ACK    (rx_ack),
      .RX_BUSY   (rx_busy),
      .FRAME_ERR (frame_err),
      .OVERRUN   (overrun),
`ifdef UART_RX_PARITY_EN
      .PARITY_ERR(parity_err),
`endif
      .ERR_CLR   (err_clr)
   );

   always #5 rxc = ~rxc;

   // ---------------- model state ----------------
   typedef struct {
      int         due;
      int         kind;   // 0 deliver, 1 frame error, 2 parity error
      logic [7:0] d;
   } ev_t;

   ev_t        evq[$];
   int         cyc       = 0;
   int         last_t0   = 0;
   int         busy_from = 0;
   int         busy_to   = 0;
   logic [7:0] m_data    = 8'h00;
   logic       m_valid   = 1'b0;
   logic       m_ferr    = 1'b0;
   logic       m_ovr     = 1'b0;
   logic       m_perr    = 1'b0;
   int         n_checks  = 0;
   int         n_pass    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s at cycle %0d: actual %0h required %0h", name, cyc, act, exp);
      end
   endtask

   // Model: apply scheduled frame outcomes and host handshake at each edge.
   initial begin
      logic       dlv, fe, pe, ovr_set;
      logic [7:0] dd;
      forever begin
         @(posedge rxc or negedge rst_n);
         if (!rst_n) begin
            m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
            busy_from = 0; busy_to = 0;
            evq.delete();
         end else begin
            cyc = cyc + 1;
            dlv = 1'b0; fe = 1'b0; pe = 1'b0; dd = 8'h00;
            while (evq.size() > 0 && evq[0].due <= cyc) begin
               if (evq[0].due == cyc) begin
                  if (evq[0].kind == 0) begin dlv = 1'b1; dd = evq[0].d; end
                  else if (evq[0].kind == 1) fe = 1'b1;
                  else pe = 1'b1;
               end
               void'(evq.pop_front());
            end
            ovr_set = 1'b0;
            if (dlv) begin
               if (!m_valid || rx_ack) begin m_data = dd; m_valid = 1'b1; end
               else ovr_set = 1'b1;
            end else if (rx_ack) begin
               m_valid = 1'b0;
            end
            if (ovr_set) m_ovr = 1'b1; else if (err_clr) m_ovr = 1'b0;
            if (fe) m_ferr = 1'b1;     else if (err_clr) m_ferr = 1'b0;
            if (pe) m_perr = 1'b1;     else if (err_clr) m_perr = 1'b0;
         end
      end
   end

   // Per-cycle comparison against the model, 1 time unit after each edge.
   initial begin
      forever begin
         @(posedge rxc);
         #1;
         check("rx_valid",  rx_valid,  m_valid);
         check("rxdata",    rxdata,    m_data);
         check("frame_err", frame_err, m_ferr);
         check("overrun",   overrun,   m_ovr);
         check("rx_busy",   rx_busy,   (cyc >= busy_from && cyc < busy_to) ? 1 : 0);
`ifdef UART_RX_PARITY_EN
         check("parity_err", parity_err, m_perr);
`endif
      end
   end

   // Drive one frame starting at the current falling edge and schedule its outcome.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
      ev_t e;
      int  t0;
      t0        = cyc + 1;
      last_t0   = t0;
      busy_from = t0 + 2;
      if (PAR != 0 && par_flip) begin
         e.due = t0 + LAT - OSR; e.kind = 2; e.d = d; evq.push_back(e);
      end
      if (stop_bit) begin
         if (!(PAR != 0 && par_flip)) begin
            e.due = t0 + LAT; e.kind = 0; e.d = d; evq.push_back(e);
         end
         busy_to = t0 + LAT;
      end else begin
         e.due = t0 + LAT; e.kind = 1; e.d = d; evq.push_back(e);
         busy_to = t0 + (SIZE + 2 + PAR) * OSR + 2;
      end
      rxd = 1'b0;
      repeat (OSR) @(negedge rxc);
      for (int i = 0; i < SIZE; i++) begin
         rxd = d[i];
         repeat (OSR) @(negedge rxc);
      end
      if (PAR != 0) begin
         rxd = (^d) ^ par_flip;
         repeat (OSR) @(negedge rxc);
      end
      rxd = stop_bit;
      repeat (OSR) @(negedge rxc);
      rxd = 1'b1;
   endtask

   task automatic wait_valid(output int lat);
      lat = -1;
      for (int i = 0; i < LAT + 50; i++) begin
         @(negedge rxc);
         if (rx_valid === 1'b1) begin
            lat = cyc - last_t0;
            break;
         end
      end
   endtask

   task automatic pulse_ack_clr(input logic ack, input logic clr);
      rx_ack  = ack;
      err_clr = clr;
      @(negedge rxc);
      rx_ack  = 1'b0;
      err_clr = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1);
   end

   initial begin
      int lat;
      repeat (4) @(negedge rxc);
      rst_n = 1'b1;
      repeat (200) @(negedge rxc);
      check("idle_valid",  rx_valid,  0);
      check("idle_busy",   rx_busy,   0);
      check("idle_rxdata", rxdata,    8'h00);
      check("idle_ferr",   frame_err, 0);
      check("idle_ovr",    overrun,   0);

      // Single frame, exact latency, ack one cycle later.
      fork
         send_frame(8'hA5, 1'b1, 1'b0);
         begin
            wait_valid(lat);
            check("latency_a5", lat, LAT_LIT);
            check("rxdata_a5", rxdata, 8'hA5);
            pulse_ack_clr(1'b1, 1'b0);
            check("ack_clears", rx_valid, 0);
         end
      join
      repeat (10) @(negedge rxc);

      // Short low glitch is rejected.
      busy_from = cyc + 3;
      busy_to   = cyc + 4 + OSR / 2;
      rxd = 1'b0;
      repeat (4) @(negedge rxc);
      rxd = 1'b1;
      repeat (40) @(negedge rxc);
      check("glitch_valid", rx_valid,  0);
      check("glitch_ferr",  frame_err, 0);
      check("glitch_busy",  rx_busy,   0);

      // Framing error, clear, then a good frame.
      send_frame(8'h3C, 1'b0, 1'b0);
      repeat (10) @(negedge rxc);
      check("ferr_set",   frame_err, 1);
      check("ferr_valid", rx_valid,  0);
      pulse_ack_clr(1'b0, 1'b1);
      check("ferr_clr", frame_err, 0);
      send_frame(8'h55, 1'b1, 1'b0);
      check("rxdata_55", rxdata,   8'h55);
      check("valid_55",  rx_valid, 1);
      pulse_ack_clr(1'b1, 1'b0);

      // Back-to-back frames without ack: overrun, first word kept.
      send_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0);
      repeat (5) @(negedge rxc);
      check("ovr_rxdata", rxdata,  8'h11);
      check("ovr_set",    overrun, 1);
      pulse_ack_clr(1'b1, 1'b1);
      check("ovr_clr", overrun, 0);

      // Same again, with ack on the delivery edge of the second word.
      send_frame(8'h11, 1'b1, 1'b0);
      fork
         send_frame(8'h22, 1'b1, 1'b0);
         begin
            @(negedge rxc);
            for (int i = 0; i < LAT + 50 && cyc != last_t0 + LAT - 1; i++) @(negedge rxc);
            pulse_ack_clr(1'b1, 1'b0);
         end
      join
      check("ackdlv_rxdata", rxdata,   8'h22);
      check("ackdlv_valid",  rx_valid, 1);
      check("ackdlv_ovr",    overrun,  0);
      pulse_ack_clr(1'b1, 1'b0);

      // Reset in the middle of a frame, then a clean frame.
      busy_from = cyc + 3;
      busy_to   = 1 << 30;
      rxd = 1'b0;
      repeat (OSR) @(negedge rxc);
      rxd = 1'b1;
      repeat (3 * OSR) @(negedge rxc);
      rst_n = 1'b0;
      repeat (3) @(negedge rxc);
      check("abort_busy",  rx_busy,  0);
      check("abort_valid", rx_valid, 0);
      rst_n = 1'b1;
      repeat (20) @(negedge rxc);
      send_frame(8'h81, 1'b1, 1'b0);
      check("rxdata_81", rxdata,   8'h81);
      check("valid_81",  rx_valid, 1);
      pulse_ack_clr(1'b1, 1'b0);

`ifdef UART_RX_PARITY_EN
      // Wrong parity bit drops the word and raises the sticky flag.
      send_frame(8'h81, 1'b1, 1'b1);
      repeat (5) @(negedge rxc);
      check("perr_set",   parity_err, 1);
      check("perr_valid", rx_valid,   0);
      pulse_ack_clr(1'b0, 1'b1);
      check("perr_clr", parity_err, 0);
`endif

      repeat (5) @(negedge rxc);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
